ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter_if.sv | 54 +++++
 rtl/ram_byte_merge.sv | 21 ++
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the fetch / load-store RAM arbiter.
// State encodings, port selects and bus widths live here.
package ram_arbiter_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RMW_MERGE = 2'd2,
    WR_ACK    = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of fetch, load/store and RAM-side signals of ram_arbiter.
// slave = the arbiter, master = requesters plus RAM.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  localparam int STRB_W = strb_w(DATA_W);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [STRB_W-1:0] ls_wstrb_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic [ADDR_W-1:0] ram_raddr_o;
  logic [ADDR_W-1:0] ram_waddr_o;
  logic              ram_we_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i,
    input  ls_wdata_i, ls_wstrb_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output ram_raddr_o, ram_waddr_o,
    output ram_we_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i,
    output ls_wdata_i, ls_wstrb_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  ram_raddr_o, ram_waddr_o,
    input  ram_we_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/ram_byte_merge.sv
// Byte-lane merge: strobed bytes from new_i, the rest from old_i.
// Purely combinational.
module ram_byte_merge
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic [DATA_W-1:0]         old_i,
  input  logic [DATA_W-1:0]         new_i,
  input  logic [strb_w(DATA_W)-1:0] strb_i,
  output logic [DATA_W-1:0]         merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < strb_w(DATA_W); i++) begin
      if (strb_i[i]) merged_o[i*8 +: 8] = new_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch and load/store.
// Define RAM_ARBITER_RMW_EN for byte-strobed read-modify-write.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int IDX_LO = 3
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  state_e state_q, state_d;
  port_e  last_q, last_d;
  port_e  owner_q, owner_d;
  addr_t  addr_q, addr_d;
  data_t  wdata_q, wdata_d;
  logic   if_rvalid_q, if_rvalid_d;
  logic   ls_rvalid_q, ls_rvalid_d;
  data_t  if_rdata_q, if_rdata_d;
  data_t  ls_rdata_q, ls_rdata_d;
  logic   ls_win, if_win;

  function automatic addr_t word_addr(input addr_t a);
    return {a[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
  endfunction

`ifdef RAM_ARBITER_RMW_EN
  logic [strb_w(DATA_W)-1:0] wstrb_q, wstrb_d;
  data_t merged;

  ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i    (bus.ram_rdata_i),
    .new_i    (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (merged)
  );
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.ls_wstrb_i;
`endif

  // On a tie the port not granted last wins
  assign ls_win = bus.ls_req_i &
                  (~bus.if_req_i | (last_q == PORT_IF));
  assign if_win = bus.if_req_i & ~ls_win;

  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rdata_o  = ls_rdata_q;

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    if_rvalid_d     = 1'b0;
    ls_rvalid_d     = 1'b0;
    if_rdata_d      = if_rdata_q;
    ls_rdata_d      = ls_rdata_q;
`ifdef RAM_ARBITER_RMW_EN
    wstrb_d         = wstrb_q;
`endif
    bus.if_gnt_o    = 1'b0;
    bus.ls_gnt_o    = 1'b0;
    bus.ram_raddr_o = '0;
    bus.ram_waddr_o = '0;
    bus.ram_we_o    = 1'b0;
    bus.ram_wdata_o = '0;
    // Outputs stay quiet while reset is held
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (ls_win) begin
            bus.ls_gnt_o = 1'b1;
            owner_d      = PORT_LS;
            last_d       = PORT_LS;
            addr_d       = word_addr(bus.ls_addr_i);
            wdata_d      = bus.ls_wdata_i;
`ifdef RAM_ARBITER_RMW_EN
            wstrb_d      = bus.ls_wstrb_i;
`endif
            if (!bus.ls_we_i) begin
              bus.ram_raddr_o = word_addr(bus.ls_addr_i);
              state_d         = RD_WAIT;
            end else begin
`ifdef RAM_ARBITER_RMW_EN
              if (&bus.ls_wstrb_i) begin
                bus.ram_we_o    = 1'b1;
                bus.ram_waddr_o = word_addr(bus.ls_addr_i);
                bus.ram_wdata_o = bus.ls_wdata_i;
                state_d         = WR_ACK;
              end else if (|bus.ls_wstrb_i) begin
                bus.ram_raddr_o = word_addr(bus.ls_addr_i);
                state_d         = RMW_MERGE;
              end else begin
                state_d         = WR_ACK;
              end
`else
              bus.ram_we_o    = 1'b1;
              bus.ram_waddr_o = word_addr(bus.ls_addr_i);
              bus.ram_wdata_o = bus.ls_wdata_i;
              state_d         = WR_ACK;
`endif
            end
          end else if (if_win) begin
            bus.if_gnt_o    = 1'b1;
            owner_d         = PORT_IF;
            last_d          = PORT_IF;
            addr_d          = word_addr(bus.if_addr_i);
            bus.ram_raddr_o = word_addr(bus.if_addr_i);
            state_d         = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (owner_q == PORT_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = bus.ram_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.ram_rdata_i;
          end
          state_d = IDLE;
        end
`ifdef RAM_ARBITER_RMW_EN
        RMW_MERGE: begin
          bus.ram_we_o    = 1'b1;
          bus.ram_waddr_o = addr_q;
          bus.ram_wdata_o = merged;
          state_d         = WR_ACK;
        end
`endif
        WR_ACK: begin
          ls_rvalid_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_IF;
      owner_q     <= PORT_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef RAM_ARBITER_RMW_EN
      wstrb_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef RAM_ARBITER_RMW_EN
      wstrb_q     <= wstrb_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle-latency RAM model.
// Expectations follow RAM_ARBITER_RMW_EN when it is defined.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  int   rv_cnt  = 0;
  int   we_snap;
  int   rv_snap;

  logic [63:0] mem [0:15];

  ram_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ram_arbiter #(.ADDR_W(64), .DATA_W(64), .IDX_LO(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o[6:3]] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_raddr_o[6:3]];
    if (bus.ram_we_o) we_cnt <= we_cnt + 1;
    if (bus.if_rvalid_o || bus.ls_rvalid_o) rv_cnt <= rv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic if_read(input string tag, input logic [63:0] a,
                         input logic [63:0] exp_addr,
                         input logic [63:0] exp_data);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    #1;
    chk({tag, "_gnt"}, bus.if_gnt_o, 1);
    chk({tag, "_raddr"}, bus.ram_raddr_o, exp_addr);
    tick();
    bus.if_req_i = 1'b0;
    chk({tag, "_rv1"}, bus.if_rvalid_o, 0);
    tick();
    chk({tag, "_rv2"}, bus.if_rvalid_o, 1);
    chk({tag, "_data"}, bus.if_rdata_o, exp_data);
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = '0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    bus.ls_wstrb_i = '0;
    repeat (2) tick();
    chk("rst_if_gnt", bus.if_gnt_o, 0);
    chk("rst_if_rv", bus.if_rvalid_o, 0);
    chk("rst_ls_rv", bus.ls_rvalid_o, 0);
    chk("rst_we", bus.ram_we_o, 0);
    chk("rst_raddr", bus.ram_raddr_o, 0);
    chk("rst_ls_rdata", bus.ls_rdata_o, 0);
    bus.if_req_i = 1'b0;
    rst_n        = 1'b1;
    tick();

    // First tie after reset: LS wins, IF follows
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_addr_i  = 64'h8;
    bus.ls_wdata_i = 64'hAAAAAAAA_BBBBBBBB;
    bus.ls_wstrb_i = 8'hFF;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 64'h8;
    #1;
    chk("tie1_ls_gnt", bus.ls_gnt_o, 1);
    chk("tie1_if_gnt", bus.if_gnt_o, 0);
    chk("full_we", bus.ram_we_o, 1);
    chk("full_waddr", bus.ram_waddr_o, 64'h8);
    chk("full_wdata", bus.ram_wdata_o, 64'hAAAAAAAA_BBBBBBBB);
    tick();
    bus.ls_req_i = 1'b0;
    chk("busy_if_gnt", bus.if_gnt_o, 0);
    chk("full_we_c1", bus.ram_we_o, 0);
    tick();
    chk("full_ls_rv", bus.ls_rvalid_o, 1);
    chk("tie1_if_next", bus.if_gnt_o, 1);
    chk("tie1_if_raddr", bus.ram_raddr_o, 64'h8);
    tick();
    bus.if_req_i = 1'b0;
    tick();
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_addr_i = 64'h8;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h10;
    #1;
    chk("tie1_if_rv", bus.if_rvalid_o, 1);
    chk("tie1_if_data", bus.if_rdata_o, 64'hAAAAAAAA_BBBBBBBB);
    chk("tie2_ls_gnt", bus.ls_gnt_o, 1);
    chk("tie2_if_gnt", bus.if_gnt_o, 0);
    tick();
    bus.ls_req_i = 1'b0;
    tick();
    chk("ls_rd_rv", bus.ls_rvalid_o, 1);
    chk("ls_rd_data", bus.ls_rdata_o, 64'hAAAAAAAA_BBBBBBBB);
    chk("tie2_if_next", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 1'b0;
    tick();
    chk("tie2_if_rv", bus.if_rvalid_o, 1);
    tick();
    chk("rv_pulse_end", bus.if_rvalid_o, 0);
    chk("ls_rdata_hold", bus.ls_rdata_o, 64'hAAAAAAAA_BBBBBBBB);

    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_addr_i  = 64'h10;
    bus.ls_wdata_i = 64'hDEADBEEF_00C0FFEE;
    bus.ls_wstrb_i = 8'hFF;
    #1;
    chk("pre_gnt", bus.ls_gnt_o, 1);
    tick();
    bus.ls_req_i = 1'b0;
    tick();
    chk("pre_rv", bus.ls_rvalid_o, 1);
    tick();

    if_read("rd10", 64'h10, 64'h10, 64'hDEADBEEF_00C0FFEE);
    chk("rd10_hold", bus.if_rdata_o, 64'hDEADBEEF_00C0FFEE);
    if_read("rd13", 64'h13, 64'h10, 64'hDEADBEEF_00C0FFEE);

    // Partial write over AAAAAAAA_BBBBBBBB
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_addr_i  = 64'h8;
    bus.ls_wdata_i = 64'h11111111_22222222;
    bus.ls_wstrb_i = 8'h0F;
    #1;
    chk("part_gnt", bus.ls_gnt_o, 1);
`ifdef RAM_ARBITER_RMW_EN
    chk("part_we_c0", bus.ram_we_o, 0);
    chk("part_raddr", bus.ram_raddr_o, 64'h8);
    tick();
    bus.ls_req_i = 1'b0;
    chk("part_we_c1", bus.ram_we_o, 1);
    chk("part_wdata", bus.ram_wdata_o, 64'hAAAAAAAA_22222222);
    tick();
    chk("part_rv_c2", bus.ls_rvalid_o, 0);
    tick();
    chk("part_rv_c3", bus.ls_rvalid_o, 1);
    tick();
    if_read("part_rb", 64'h8, 64'h8, 64'hAAAAAAAA_22222222);
`else
    chk("part_we_c0", bus.ram_we_o, 1);
    chk("part_wdata", bus.ram_wdata_o, 64'h11111111_22222222);
    tick();
    bus.ls_req_i = 1'b0;
    tick();
    chk("part_rv_c2", bus.ls_rvalid_o, 1);
    tick();
    if_read("part_rb", 64'h8, 64'h8, 64'h11111111_22222222);
`endif

    we_snap        = we_cnt;
    bus.ls_req_i   = 1'b1;
    bus.ls_addr_i  = 64'h10;
    bus.ls_wdata_i = 64'h55555555_55555555;
    bus.ls_wstrb_i = 8'h00;
    #1;
    chk("z_gnt", bus.ls_gnt_o, 1);
    tick();
    bus.ls_req_i = 1'b0;
    tick();
    chk("z_rv_c2", bus.ls_rvalid_o, 1);
    tick();
`ifdef RAM_ARBITER_RMW_EN
    chk("z_we_count", we_cnt - we_snap, 0);
    if_read("z_rb", 64'h10, 64'h10, 64'hDEADBEEF_00C0FFEE);
`else
    chk("z_we_count", we_cnt - we_snap, 1);
    if_read("z_rb", 64'h10, 64'h10, 64'h55555555_55555555);
`endif

    we_snap       = we_cnt;
    rv_snap       = rv_cnt;
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 64'h10;
`ifdef RAM_ARBITER_RMW_EN
    bus.ls_we_i    = 1'b1;
    bus.ls_wdata_i = 64'hFFFFFFFF_FFFFFFFF;
    bus.ls_wstrb_i = 8'h01;
`else
    bus.ls_we_i    = 1'b0;
`endif
    #1;
    chk("mid_gnt", bus.ls_gnt_o, 1);
    tick();
    bus.ls_req_i = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_we", bus.ram_we_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_no_rv", rv_cnt - rv_snap, 0);
    chk("mid_no_we", we_cnt - we_snap, 0);
`ifdef RAM_ARBITER_RMW_EN
    if_read("mid_rb", 64'h10, 64'h10, 64'hDEADBEEF_00C0FFEE);
`else
    if_read("mid_rb", 64'h10, 64'h10, 64'h55555555_55555555);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
